// File: rtl/calc_arbiter.sv
// Round-robin arbiter that lets N_REQ requesters share one compute unit.
// It runs one job at a time: grant, issue, wait for done or timeout, then hold the response.
module calc_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*16-1:0]      req_x,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [$clog2(N_REQ)-1:0] resp_id,
  output logic [31:0]              resp_y,
  output logic                     resp_err,
  output logic                     cu_start,
  output logic [15:0]              cu_x,
  input  logic [31:0]              cu_y,
  input  logic                     cu_done,
  output logic                     busy
);
  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   last_q, last_d;
  logic [IW-1:0]   id_q, id_d;
  logic [15:0]     x_q, x_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            first_q, first_d;
  logic [31:0]     y_q, y_d;
  logic            err_q, err_d;
  logic [N_REQ-1:0] grant;
  logic            win_found;
  logic [IW-1:0]   win;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      last_q  <= IW'(N_REQ - 1);
      id_q    <= '0;
      x_q     <= '0;
      cnt_q   <= '0;
      first_q <= 1'b0;
      y_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      x_q     <= x_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      y_q     <= y_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    id_d      = id_q;
    x_d       = x_q;
    cnt_d     = cnt_q;
    first_d   = first_q;
    y_d       = y_q;
    err_d     = err_q;
    grant     = '0;
    win_found = 1'b0;
    win       = '0;

    // Search starts just after the last granted requester.
    for (int off = 1; off <= N_REQ; off++) begin
      int idx;
      idx = (int'(last_q) + off) % N_REQ;
      if (!win_found && req_valid[idx]) begin
        win_found = 1'b1;
        win       = IW'(idx);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          grant[win] = 1'b1;
          id_d       = win;
          x_d        = req_x[int'(win)*16 +: 16];
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        first_d = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // The first WAIT cycle may still see a done level left over from the previous job.
        first_d = 1'b0;
        if (!first_q) begin
          if (cu_done) begin
            y_d     = cu_y;
            err_d   = 1'b0;
            state_d = S_RESP;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            y_d     = '0;
            err_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          last_d  = id_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign req_ready  = rst ? '0 : grant;
  assign busy       = (state_q != S_IDLE);
  assign cu_start   = (state_q == S_ISSUE);
  assign cu_x       = (state_q == S_ISSUE || state_q == S_WAIT) ? x_q : 16'd0;
  assign resp_valid = (state_q == S_RESP);
  assign resp_id    = id_q;
  assign resp_y     = y_q;
  assign resp_err   = err_q;
endmodule

// File: tb/tb_calc_arbiter.sv
// Directed bench for calc_arbiter with a simple 5-cycle CU model.
module tb_calc_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [63:0] req_x;
  logic [3:0]  req_ready;
  logic        resp_valid, resp_ready;
  logic [1:0]  resp_id;
  logic [31:0] resp_y;
  logic        resp_err;
  logic        cu_start;
  logic [15:0] cu_x;
  logic [31:0] cu_y;
  logic        cu_done;
  logic        busy;

  int tests = 0;
  int fails = 0;

  logic [2:0]  lat;
  logic        mdone;
  logic [31:0] my;
  logic        cu_mute, stale_force;

  calc_arbiter #(.N_REQ(4), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_x(req_x), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_y(resp_y),
    .resp_err(resp_err), .cu_start(cu_start), .cu_x(cu_x), .cu_y(cu_y), .cu_done(cu_done),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // CU model: 10 -> 38, -8 -> -4, done pulses 5 cycles after start.
  always @(posedge clk) begin
    if (rst) begin
      lat <= 3'd0; mdone <= 1'b0; my <= 32'd0;
    end else if (cu_start) begin
      lat   <= 3'd4;
      mdone <= 1'b0;
      my    <= (cu_x == 16'd10) ? 32'd38 : (cu_x == 16'hFFF8) ? 32'hFFFF_FFFC : 32'd0;
    end else if (lat == 3'd1) begin
      lat   <= 3'd0;
      mdone <= ~cu_mute;
    end else begin
      mdone <= 1'b0;
      if (lat > 3'd1) lat <= lat - 3'd1;
    end
  end
  assign cu_done = mdone | stale_force;
  assign cu_y    = stale_force ? 32'h0000_DEAD : my;

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_resp(input int start, output int n);
    n = start;
    while (!resp_valid && n < 200) begin tick; n++; end
  endtask

  task automatic handshake;
    resp_ready = 1'b1; tick; resp_ready = 1'b0;
  endtask

  // Called in an IDLE cycle where the expected winner is already requesting.
  task automatic run_job(input string tag, input int id, input logic [15:0] x,
                         input logic [31:0] y, input logic err, input int exp_lat);
    int n;
    chk({tag, "_ready"}, 32'(req_ready), 32'(4'b1 << id));
    tick;
    chk({tag, "_start"}, 32'(cu_start), 32'd1);
    chk({tag, "_cux"}, 32'(cu_x), 32'(x));
    wait_resp(0, n);
    chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
    chk({tag, "_id"}, 32'(resp_id), 32'(id));
    chk({tag, "_y"}, resp_y, y);
    chk({tag, "_err"}, 32'(resp_err), 32'(err));
    handshake;
  endtask

  initial begin
    int n;
    rst = 1'b1; req_valid = 4'b0100; req_x = '0; resp_ready = 1'b0;
    cu_mute = 1'b0; stale_force = 1'b0;
    req_x[47:32] = 16'd10;
    tick; tick;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rvalid", 32'(resp_valid), 32'd0);
    chk("rst_start", 32'(cu_start), 32'd0);
    chk("rst_cux", 32'(cu_x), 32'd0);
    chk("rst_y", resp_y, 32'd0);
    chk("rst_err", 32'(resp_err), 32'd0);
    chk("rst_id", 32'(resp_id), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);

    // Single job from requester 2.
    rst = 1'b0; #1;
    chk("s1_idle_busy", 32'(busy), 32'd0);
    run_job("s1", 2, 16'd10, 32'd38, 1'b0, 6);
    chk("s1_after_rv", 32'(resp_valid), 32'd0);
    chk("s1_after_busy", 32'(busy), 32'd0);

    // Contention: all requesters, x = -8.
    req_valid = 4'b0000; rst = 1'b1; tick;
    req_x = {4{16'hFFF8}}; req_valid = 4'b1111; rst = 1'b0; #1;
    run_job("c0", 0, 16'hFFF8, 32'hFFFF_FFFC, 1'b0, 6);
    run_job("c1", 1, 16'hFFF8, 32'hFFFF_FFFC, 1'b0, 6);
    run_job("c2", 2, 16'hFFF8, 32'hFFFF_FFFC, 1'b0, 6);
    run_job("c3", 3, 16'hFFF8, 32'hFFFF_FFFC, 1'b0, 6);
    run_job("c4", 0, 16'hFFF8, 32'hFFFF_FFFC, 1'b0, 6);

    // Timeout: CU never completes.
    req_valid = 4'b0000; rst = 1'b1; tick;
    cu_mute = 1'b1; req_x = {4{16'd10}}; req_valid = 4'b0010; rst = 1'b0; #1;
    run_job("to", 1, 16'd10, 32'd0, 1'b1, 66);
    cu_mute = 1'b0;

    // Backpressure: last grant was 1, so requester 2 wins next.
    req_valid = 4'b1111; #1;
    chk("bp_ready", 32'(req_ready), 32'b0100);
    tick;
    wait_resp(0, n);
    chk("bp_lat", 32'(n), 32'd6);
    for (int i = 0; i < 10; i++) begin
      chk("bp_rv", 32'(resp_valid), 32'd1);
      chk("bp_id", 32'(resp_id), 32'd2);
      chk("bp_y", resp_y, 32'd38);
      chk("bp_noready", 32'(req_ready), 32'd0);
      tick;
    end
    handshake;
    chk("bp_next", 32'(req_ready), 32'b1000);

    // Stale done held across ISSUE and the first WAIT cycle.
    req_valid = 4'b0000; rst = 1'b1; tick;
    req_x = {4{16'hFFF8}}; req_valid = 4'b0001; rst = 1'b0; #1;
    chk("st_ready", 32'(req_ready), 32'b0001);
    stale_force = 1'b1;
    tick;
    req_valid = 4'b0000;
    chk("st_start", 32'(cu_start), 32'd1);
    tick;
    chk("st_wait", 32'(resp_valid), 32'd0);
    tick;
    stale_force = 1'b0;
    wait_resp(2, n);
    chk("st_lat", 32'(n), 32'd6);
    chk("st_y", resp_y, 32'hFFFF_FFFC);
    chk("st_err", 32'(resp_err), 32'd0);
    handshake;

    // Reset mid-WAIT; requester 0 must win afterwards.
    req_x = {4{16'd10}}; req_valid = 4'b0010; #1;
    chk("rw_ready", 32'(req_ready), 32'b0010);
    tick; tick; tick;
    chk("rw_busy_pre", 32'(busy), 32'd1);
    rst = 1'b1; tick; rst = 1'b0; #1;
    chk("rw_busy", 32'(busy), 32'd0);
    chk("rw_rv", 32'(resp_valid), 32'd0);
    chk("rw_cux", 32'(cu_x), 32'd0);
    req_valid = 4'b1111; #1;
    chk("rw_next", 32'(req_ready), 32'b0001);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
